// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, cause bit
// positions and default sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_t;

  localparam int DEF_NDOM  = 3;
  localparam int DEF_NSRC  = 3;
  localparam int DEF_HOLD  = 4;
  localparam int DEF_DELAY = 8;

  localparam int CAUSE_DBG  = 0;
  localparam int CAUSE_WDT  = 1;
  localparam int CAUSE_SW   = 2;
  localparam int CAUSE_LOCK = DEF_NSRC;

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable saturating down-counter; expired is high once the count reaches 1,
// so a load of N yields expiry on the Nth following edge.
module reset_seq_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          expired
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (load)
      cnt_q <= value;
    else if (cnt_q > CW'(1))
      cnt_q <= cnt_q - CW'(1);
  end

  assign expired = (cnt_q <= CW'(1));

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: asserts all domains, waits for clock lock, then releases
// domains in index order and arbitrates reset requests once running.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int NDOM  = DEF_NDOM,
  parameter int NSRC  = DEF_NSRC,
  parameter int HOLD  = DEF_HOLD,
  parameter int DELAY = DEF_DELAY
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pll_lock,
  input  logic [NSRC-1:0] rst_req,
  output logic [NSRC-1:0] rst_ack,
  output logic [NDOM-1:0] dom_reset_n,
  output logic [NSRC:0]   rst_cause,
  output logic            seq_busy,
  output logic            done
);

  localparam int CW = $clog2(DELAY + HOLD + 1);
  localparam int KW = (NDOM > 1) ? $clog2(NDOM) : 1;

  seq_state_t      state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [NDOM-1:0] dom_d;
  logic [NSRC-1:0] ack_d;
  logic [NSRC:0]   cause_d;
  logic            tmr_load;
  logic [CW-1:0]   tmr_value;
  logic            tmr_expired;

  // Isolates the lowest set bit, giving fixed lowest-index-wins priority.
  function automatic logic [NSRC-1:0] lowest_onehot(input logic [NSRC-1:0] req);
    return req & (~req + NSRC'(1));
  endfunction

  reset_seq_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    dom_d     = dom_reset_n;
    ack_d     = '0;
    cause_d   = rst_cause;
    tmr_load  = 1'b0;
    tmr_value = CW'(HOLD);

    case (state_q)
      ST_ASSERT: begin
        dom_d = '0;
        if (tmr_expired) begin
          state_d  = ST_WAIT_LOCK;
          tmr_load = 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (pll_lock) begin
          state_d   = ST_RELEASE;
          k_d       = '0;
          tmr_load  = 1'b1;
          tmr_value = CW'(DELAY);
        end
      end
      ST_RELEASE: begin
        if (!pll_lock) begin
          state_d  = ST_ASSERT;
          dom_d    = '0;
          cause_d  = {1'b1, {NSRC{1'b0}}};
          tmr_load = 1'b1;
        end else if (tmr_expired) begin
          dom_d[k_q] = 1'b1;
          tmr_load   = 1'b1;
          tmr_value  = CW'(DELAY);
          if (k_q == KW'(NDOM - 1))
            state_d = ST_RUN;
          else
            k_d = k_q + KW'(1);
        end
      end
      ST_RUN: begin
        // Lock loss outranks any pending request on the same edge.
        if (!pll_lock) begin
          state_d  = ST_ASSERT;
          dom_d    = '0;
          cause_d  = {1'b1, {NSRC{1'b0}}};
          tmr_load = 1'b1;
        end else if (|rst_req) begin
          state_d  = ST_ASSERT;
          dom_d    = '0;
          ack_d    = lowest_onehot(rst_req);
          cause_d  = {1'b0, lowest_onehot(rst_req)};
          tmr_load = 1'b1;
        end
      end
      default: begin
        state_d  = ST_ASSERT;
        dom_d    = '0;
        tmr_load = 1'b1;
      end
    endcase

    if (reset) begin
      tmr_load  = 1'b1;
      tmr_value = CW'(HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      k_q         <= '0;
      dom_reset_n <= '0;
      rst_ack     <= '0;
      rst_cause   <= '0;
      done        <= 1'b0;
      seq_busy    <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      dom_reset_n <= dom_d;
      rst_ack     <= ack_d;
      rst_cause   <= cause_d;
      done        <= (state_d == ST_RUN);
      seq_busy    <= (state_d != ST_RUN);
    end
  end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with default parameters; edge numbers are
// counted from the first edge that samples reset low.
module tb_reset_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic [2:0] rst_req;
  logic [2:0] rst_ack;
  logic [2:0] dom_reset_n;
  logic [3:0] rst_cause;
  logic       seq_busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int ed = 0;

  reset_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .rst_req     (rst_req),
    .rst_ack     (rst_ack),
    .dom_reset_n (dom_reset_n),
    .rst_cause   (rst_cause),
    .seq_busy    (seq_busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: got %0h expected %0h", tag, ed, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ed++;
    chk("ack_onehot", 32'($countones(rst_ack) <= 1), 32'd1);
  endtask

  task automatic run_to(input int n);
    while (ed < n) tick();
  endtask

  task automatic chk_state(input string tag, input logic [2:0] dom, input logic [2:0] ack,
                           input logic [3:0] cause, input logic dn);
    chk({tag, "_dom"},   32'(dom_reset_n), 32'(dom));
    chk({tag, "_ack"},   32'(rst_ack),     32'(ack));
    chk({tag, "_cause"}, 32'(rst_cause),   32'(cause));
    chk({tag, "_done"},  32'(done),        32'(dn));
    chk({tag, "_busy"},  32'(seq_busy),    32'(!dn));
  endtask

  initial begin
    reset    = 1'b1;
    pll_lock = 1'b1;
    rst_req  = 3'b000;
    repeat (3) tick();
    ed    = 0;
    reset = 1'b0;
    chk_state("reset", 3'b000, 3'b000, 4'b0000, 1'b0);

    // Power-up: releases at 13/21/29
    run_to(12); chk_state("pu_e12", 3'b000, 3'b000, 4'b0000, 1'b0);
    run_to(13); chk_state("pu_e13", 3'b001, 3'b000, 4'b0000, 1'b0);
    run_to(20); chk("pu_e20_dom", 32'(dom_reset_n), 32'h1);
    run_to(21); chk("pu_e21_dom", 32'(dom_reset_n), 32'h3);
    run_to(28); chk_state("pu_e28", 3'b011, 3'b000, 4'b0000, 1'b0);
    run_to(29); chk_state("pu_e29", 3'b111, 3'b000, 4'b0000, 1'b1);

    // Arbitration: 110 -> watchdog wins, software held until next done
    rst_req = 3'b110;
    run_to(30); chk_state("arb_e30", 3'b000, 3'b010, 4'b0010, 1'b0);
    rst_req = 3'b100;
    run_to(31); chk_state("arb_e31", 3'b000, 3'b000, 4'b0010, 1'b0);
    run_to(42); chk("arb_e42_dom", 32'(dom_reset_n), 32'h0);
    run_to(43); chk("arb_e43_dom", 32'(dom_reset_n), 32'h1);
    run_to(51); chk_state("arb_e51", 3'b011, 3'b000, 4'b0010, 1'b0);
    run_to(59); chk_state("arb_e59", 3'b111, 3'b000, 4'b0010, 1'b1);
    run_to(60); chk_state("arb_e60", 3'b000, 3'b100, 4'b0100, 1'b0);
    rst_req = 3'b000;
    run_to(61); chk("arb_e61_ack", 32'(rst_ack), 32'h0);

    // Lock loss on the edge after dom0 release (dom0 at 73)
    run_to(73); chk("ll_e73_dom", 32'(dom_reset_n), 32'h1);
    pll_lock = 1'b0;
    run_to(74); chk_state("ll_e74", 3'b000, 3'b000, 4'b1000, 1'b0);
    run_to(90); chk_state("ll_e90", 3'b000, 3'b000, 4'b1000, 1'b0);
    pll_lock = 1'b1;
    run_to(98);  chk("ll_e98_dom", 32'(dom_reset_n), 32'h0);
    run_to(99);  chk("ll_e99_dom", 32'(dom_reset_n), 32'h1);
    run_to(115); chk_state("ll_e115", 3'b111, 3'b000, 4'b1000, 1'b1);

    // Lock loss and debug request on the same RUN edge
    pll_lock = 1'b0;
    rst_req  = 3'b001;
    run_to(116); chk_state("llreq_e116", 3'b000, 3'b000, 4'b1000, 1'b0);
    pll_lock = 1'b1;
    run_to(130); chk_state("llreq_e130", 3'b001, 3'b000, 4'b1000, 1'b0);
    run_to(145); chk_state("llreq_e145", 3'b111, 3'b000, 4'b1000, 1'b1);
    run_to(146); chk_state("llreq_e146", 3'b000, 3'b001, 4'b0001, 1'b0);
    rst_req = 3'b000;

    // Reset pulse mid-RELEASE after dom1 release (at 167)
    run_to(167); chk("rr_e167_dom", 32'(dom_reset_n), 32'h3);
    reset = 1'b1;
    run_to(168); chk_state("rr_e168", 3'b000, 3'b000, 4'b0000, 1'b0);
    reset = 1'b0;
    run_to(180); chk("rr_e180_dom", 32'(dom_reset_n), 32'h0);
    run_to(181); chk("rr_e181_dom", 32'(dom_reset_n), 32'h1);
    run_to(189); chk("rr_e189_dom", 32'(dom_reset_n), 32'h3);
    run_to(197); chk_state("rr_e197", 3'b111, 3'b000, 4'b0000, 1'b1);

    // Late lock: new base at 198, lock rises at base+40
    reset    = 1'b1;
    pll_lock = 1'b0;
    run_to(198); chk_state("late_rst", 3'b000, 3'b000, 4'b0000, 1'b0);
    reset = 1'b0;
    run_to(238); chk_state("late_e40", 3'b000, 3'b000, 4'b0000, 1'b0);
    pll_lock = 1'b1;
    run_to(246); chk("late_e48_dom", 32'(dom_reset_n), 32'h0);
    run_to(247); chk("late_e49_dom", 32'(dom_reset_n), 32'h1);
    run_to(262); chk_state("late_e64", 3'b011, 3'b000, 4'b0000, 1'b0);
    run_to(263); chk_state("late_e65", 3'b111, 3'b000, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 Parameter NDOM, default 3, number of reset domains released in order (index 0 first).
REQ-002 Parameter NSRC, default 3, number of reset requesters (0 = debug, 1 = watchdog, 2 = software).
REQ-003 Parameter HOLD, default 4, cycles all domains stay asserted in ASSERT (HOLD >= 1).
REQ-004 Parameter DELAY, default 8, cycles between consecutive domain releases (DELAY >= 1).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high block reset.
REQ-007 pll_lock  input  1  clock-source lock; level.
REQ-008 rst_req  input  NSRC  per-source reset request; level, held by source until acked.
REQ-009 rst_ack  output  NSRC  one-cycle pulse to the accepted source.
REQ-010 dom_reset_n  output  NDOM  active-low per-domain reset, registered.
REQ-011 rst_cause  output  NSRC+1  one-hot cause of last sequence; bit NSRC = lock loss; all-zero = power-on.
REQ-012 seq_busy  output  1  high whenever state != RUN.
REQ-013 done  output  1  high only in RUN (all domains released).

Function
REQ-014 The FSM SHALL have states ASSERT, WAIT_LOCK, RELEASE and RUN.
REQ-015 ASSERT: all dom_reset_n = 0; stay exactly HOLD cycles, then go to WAIT_LOCK.
REQ-016 WAIT_LOCK: go to RELEASE on the edge that samples pll_lock = 1; wait indefinitely otherwise.
REQ-017 RELEASE: domain index k (starting at 0) released (dom_reset_n[k] <= 1) DELAY cycles after entering RELEASE or after the previous release.
REQ-018 On the edge releasing domain NDOM-1: go to RUN; done = 1 and seq_busy = 0 from that edge.
REQ-019 Timing, with reset low from edge 1, pll_lock = 1, HOLD = 4, DELAY = 8: domains released at edges 13, 21 and 29.
REQ-020 Released domains stay released until the next ASSERT.
REQ-021 In RUN, a nonzero rst_req SHALL be accepted: fixed priority, lowest index wins.
REQ-022 On acceptance, on the sampling edge: rst_ack[winner] = 1 for one cycle; rst_cause = one-hot winner; all dom_reset_n = 0; done = 0; state = ASSERT.
REQ-023 Requests sampled outside RUN SHALL be ignored (no ack); a held level is accepted on the next RUN cycle.
REQ-024 pll_lock = 0 sampled in RELEASE or RUN: state = ASSERT, all dom_reset_n = 0, rst_cause = bit NSRC; no rst_ack.
REQ-025 Lock loss takes priority over rst_req on the same edge.
REQ-026 pll_lock = 0 during ASSERT or WAIT_LOCK: no effect beyond WAIT_LOCK gating.
REQ-027 The delay counter SHALL be $clog2(DELAY+HOLD+1) bits; it reloads on every state entry and release and never wraps.
REQ-028 rst_ack SHALL never have more than one bit set.

Reset
REQ-029 While reset = 1 at an edge: state = ASSERT, counter loaded with HOLD, k = 0, dom_reset_n = 0, rst_ack = 0, rst_cause = 0, done = 0, seq_busy = 1.
REQ-030 Reset SHALL override all other inputs, including mid-RELEASE; the sequence restarts from ASSERT.
REQ-031 rst_cause SHALL be cleared only by reset, not by request-triggered sequences.

Structure
REQ-032 Package reset_seq_pkg SHALL hold: the state enum; cause bit indices (CAUSE_DBG = 0, CAUSE_WDT = 1, CAUSE_SW = 2, CAUSE_LOCK = NSRC); and default parameter constants.
REQ-033 The loadable down-counter SHALL be sub-module reset_seq_timer (inputs load and value; output expired); there are no other sub-modules.
REQ-034 All outputs SHALL be registered; there is no combinational path from input to output.

Verification
REQ-035 Power-up: reset 3 cycles, pll_lock = 1 -> releases at edges 13/21/29, done at 29, rst_cause = 000.
REQ-036 Late lock: pll_lock rises at edge 40 -> dom0 released at edge 49, dom2 at edge 65.
REQ-037 Arbitration: in RUN, rst_req = 110 -> rst_ack = 010 for one cycle, rst_cause = 0010, all domains asserted, full sequence repeats; the held bit 2 is acked after the next done.
REQ-038 Lock loss: pll_lock = 0 at the edge after dom0 is released -> all asserted, rst_cause = 1000, no ack.
REQ-039 Lock loss and rst_req = 001 on the same RUN edge -> rst_cause = 1000, rst_ack = 000.
REQ-040 Reset pulsed mid-RELEASE (after dom1 released) -> all dom_reset_n = 0 next edge, rst_cause = 000, sequence timing restarts per REQ-019.
